// File: rtl/align_lock_ctrl_pkg.sv
// align_pkg: definitions shared by the link-alignment controller and the
// word aligner.
//   SYNC_WORD      frame sync pattern searched for in the aligned stream
//   ST_*           controller state encodings
//   state_e        controller state type built on those encodings
//   sat_inc8       8-bit increment that sticks at 255
package align_pkg;

    localparam logic [31:0] SYNC_WORD = 32'hF731_8CEF;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_HUNT   = 3'd2;
    localparam logic [2:0] ST_VERIFY = 3'd3;
    localparam logic [2:0] ST_LOCKED = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_INIT   = ST_INIT,
        S_HUNT   = ST_HUNT,
        S_VERIFY = ST_VERIFY,
        S_LOCKED = ST_LOCKED
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/align_lock_ctrl_if.sv
// align_lock_ctrl_if: word path between the aligner, the lock controller
// and the downstream deframer.
//   ALIGNED/DIPUSH/DIN     aligner status and aligned word stream
//   PHY_INIT               aligner clear request
//   DOPUSH/DOUT/FRAME_START qualified payload stream
// slave  : controller view; master : environment (aligner + deframer) view.
interface align_lock_ctrl_if;
    logic        ALIGNED;
    logic        DIPUSH;
    logic [31:0] DIN;
    logic        PHY_INIT;
    logic        DOPUSH;
    logic [31:0] DOUT;
    logic        FRAME_START;

    modport slave (
        input  ALIGNED, DIPUSH, DIN,
        output PHY_INIT, DOPUSH, DOUT, FRAME_START
    );

    modport master (
        output ALIGNED, DIPUSH, DIN,
        input  PHY_INIT, DOPUSH, DOUT, FRAME_START
    );
endinterface

// File: rtl/align_lock_ctrl_pos.sv
// frame_pos_cnt: modulo-FRAME_LEN word-position counter.
//   CLK, RSTX  clock, synchronous active-low reset
//   load_i     set position to 1 (word after a sync just found)
//   en_i       advance by one valid word, wrapping to 0
//   pos_o      current word position (0 = expected sync slot)
module frame_pos_cnt #(
    parameter  int unsigned FRAME_LEN = 64,
    localparam int unsigned PW        = $clog2(FRAME_LEN)
) (
    input  logic          CLK,
    input  logic          RSTX,
    input  logic          load_i,
    input  logic          en_i,
    output logic [PW-1:0] pos_o
);
    localparam logic [PW-1:0] POS_LAST = PW'(FRAME_LEN - 1);

    logic [PW-1:0] pos_q, pos_d;

    always_comb begin
        pos_d = pos_q;
        if (load_i) begin
            pos_d = PW'(1);
        end else if (en_i) begin
            pos_d = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTX) pos_q <= '0;
        else       pos_q <= pos_d;
    end

    assign pos_o = pos_q;
endmodule

// File: rtl/align_lock_ctrl.sv
// align_lock_ctrl: sequences the word aligner, confirms that SYNC_WORD
// recurs every FRAME_LEN words, declares lock and forwards payload.
//   CLK, RSTX   clock, synchronous active-low reset
//   LINK_EN     low forces IDLE
//   bus         aligner input stream, PHY_INIT, payload output stream
//   LOCKED      high while in LOCKED
//   LOS         one-cycle pulse on LOCKED -> INIT
//   RETRY_CNT   saturating count of hunt timeouts and sync losses
module align_lock_ctrl
    import align_pkg::*;
#(
    parameter int unsigned FRAME_LEN  = 64,
    parameter int unsigned INIT_CYC   = 4,
    parameter int unsigned HUNT_TO    = 1024,
    parameter int unsigned LOCK_CNT   = 3,
    parameter int unsigned UNLOCK_CNT = 4
) (
    input  logic                   CLK,
    input  logic                   RSTX,
    input  logic                   LINK_EN,
    align_lock_ctrl_if.slave       bus,
    output logic                   LOCKED,
    output logic                   LOS,
    output logic [7:0]             RETRY_CNT
);
    localparam int unsigned PW = $clog2(FRAME_LEN);
    localparam int unsigned IW = $clog2(INIT_CYC + 1);
    localparam int unsigned HW = $clog2(HUNT_TO + 1);
    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam int unsigned MW = $clog2(UNLOCK_CNT + 1);

    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYC - 1);
    localparam logic [HW-1:0] HUNT_LAST = HW'(HUNT_TO - 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
    localparam logic [MW-1:0] MISS_LAST = MW'(UNLOCK_CNT - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] init_q, init_d;
    logic [HW-1:0] hunt_q, hunt_d;
    logic [GW-1:0] good_q, good_d;
    logic [MW-1:0] miss_q, miss_d;
    logic          phy_init_q, phy_init_d;
    logic          dopush_q, dopush_d;
    logic [31:0]   dout_q, dout_d;
    logic          fs_q, fs_d;
    logic          locked_q, locked_d;
    logic          los_q, los_d;
    logic [7:0]    retry_q, retry_d;

    logic          pos_load, pos_en, restart;
    logic [PW-1:0] pos;
    logic          is_sync;

    frame_pos_cnt #(.FRAME_LEN(FRAME_LEN)) u_pos (
        .CLK    (CLK),
        .RSTX   (RSTX),
        .load_i (pos_load),
        .en_i   (pos_en),
        .pos_o  (pos)
    );

    assign is_sync = (bus.DIN == SYNC_WORD);

    always_comb begin
        state_d    = state_q;
        init_d     = init_q;
        hunt_d     = hunt_q;
        good_d     = good_q;
        miss_d     = miss_q;
        phy_init_d = phy_init_q;
        dopush_d   = 1'b0;
        dout_d     = dout_q;
        fs_d       = 1'b0;
        los_d      = 1'b0;
        retry_d    = retry_q;
        pos_load   = 1'b0;
        pos_en     = 1'b0;
        restart    = 1'b0;

        if (!LINK_EN) begin
            state_d    = S_IDLE;
            phy_init_d = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d    = S_INIT;
                    init_d     = '0;
                    phy_init_d = 1'b1;
                end
                S_INIT: begin
                    if (init_q == INIT_LAST) begin
                        state_d    = S_HUNT;
                        phy_init_d = 1'b0;
                        hunt_d     = '0;
                    end else begin
                        init_d = init_q + IW'(1);
                    end
                end
                S_HUNT: begin
                    if (bus.DIPUSH) begin
                        if (bus.ALIGNED && is_sync) begin
                            pos_load = 1'b1;
                            good_d   = GW'(1);
                            miss_d   = '0;
                            state_d  = (LOCK_CNT == 1) ? S_LOCKED : S_VERIFY;
                        end else if (hunt_q == HUNT_LAST) begin
                            restart = 1'b1;
                        end else begin
                            hunt_d = hunt_q + HW'(1);
                        end
                    end
                end
                S_VERIFY: begin
                    if (!bus.ALIGNED) begin
                        restart = 1'b1;
                    end else if (bus.DIPUSH) begin
                        pos_en = 1'b1;
                        if (pos == '0) begin
                            if (!is_sync) begin
                                restart = 1'b1;
                            end else if (good_q == GOOD_LAST) begin
                                state_d = S_LOCKED;
                                miss_d  = '0;
                            end else begin
                                good_d = good_q + GW'(1);
                            end
                        end
                    end
                end
                S_LOCKED: begin
                    if (!bus.ALIGNED) begin
                        restart = 1'b1;
                        los_d   = 1'b1;
                    end else if (bus.DIPUSH) begin
                        pos_en = 1'b1;
                        if (pos == '0) begin
                            // Sync slot is consumed here and never forwarded.
                            if (is_sync) begin
                                miss_d = '0;
                            end else if (miss_q == MISS_LAST) begin
                                restart = 1'b1;
                                los_d   = 1'b1;
                            end else begin
                                miss_d = miss_q + MW'(1);
                            end
                        end else begin
                            dopush_d = 1'b1;
                            dout_d   = bus.DIN;
                            fs_d     = (pos == PW'(1));
                        end
                    end
                end
                default: begin
                    state_d    = S_IDLE;
                    phy_init_d = 1'b1;
                end
            endcase
        end

        // Every abnormal exit re-initialises the aligner and counts one retry.
        if (restart) begin
            state_d    = S_INIT;
            init_d     = '0;
            phy_init_d = 1'b1;
            retry_d    = sat_inc8(retry_q);
        end

        locked_d = (state_d == S_LOCKED);
    end

    always_ff @(posedge CLK) begin
        if (!RSTX) begin
            state_q    <= S_IDLE;
            init_q     <= '0;
            hunt_q     <= '0;
            good_q     <= '0;
            miss_q     <= '0;
            phy_init_q <= 1'b1;
            dopush_q   <= 1'b0;
            dout_q     <= '0;
            fs_q       <= 1'b0;
            locked_q   <= 1'b0;
            los_q      <= 1'b0;
            retry_q    <= '0;
        end else begin
            state_q    <= state_d;
            init_q     <= init_d;
            hunt_q     <= hunt_d;
            good_q     <= good_d;
            miss_q     <= miss_d;
            phy_init_q <= phy_init_d;
            dopush_q   <= dopush_d;
            dout_q     <= dout_d;
            fs_q       <= fs_d;
            locked_q   <= locked_d;
            los_q      <= los_d;
            retry_q    <= retry_d;
        end
    end

    assign bus.PHY_INIT    = phy_init_q;
    assign bus.DOPUSH      = dopush_q;
    assign bus.DOUT        = dout_q;
    assign bus.FRAME_START = fs_q;
    assign LOCKED          = locked_q;
    assign LOS             = los_q;
    assign RETRY_CNT       = retry_q;
endmodule

// File: doc/align_lock_ctrl.md
# align_lock_ctrl

Link-alignment controller that sequences the 32-bit `word_align` aligner and qualifies its output. It drives the aligner's `PHY_INIT`, watches `ALIGNED` and the aligned word stream, and confirms that sync word 32'hF731_8CEF recurs every `FRAME_LEN` words. It declares lock, forwards payload words only while locked, and re-initialises the aligner after a hunt timeout or a loss of sync. It sits between `word_align` and the frame deframer.

## Interface
Parameters:
- `FRAME_LEN`, 64: words per frame, including the sync word at position 0; range 4..65535.
- `INIT_CYC`, 4: cycles `PHY_INIT` is held high per initialisation; range ≥1.
- `HUNT_TO`, 1024: valid words allowed in HUNT before a retry.
- `LOCK_CNT`, 3: consecutive correct syncs needed to enter LOCKED; the first sync found counts as 1.
- `UNLOCK_CNT`, 4: consecutive missed syncs that drop LOCKED.

Ports:
- `CLK`  in  1  clock; single clock domain.
- `RSTX`  in  1  reset, synchronous, active-low.
- `LINK_EN`  in  1  enable; low forces IDLE.
- `ALIGNED`  in  1  from aligner.
- `DIPUSH`  in  1  valid, from aligner `DOPUSH`.
- `DIN`  in  32  aligned word, from aligner `DOUT`.
- `PHY_INIT`  out  1  registered; clears the aligner.
- `DOPUSH`  out  1  payload valid.
- `DOUT`  out  32  payload word.
- `FRAME_START`  out  1  with `DOPUSH`; marks the first payload word of a frame.
- `LOCKED`  out  1  high in LOCKED state.
- `LOS`  out  1  one-cycle pulse on LOCKED→INIT.
- `RETRY_CNT`  out  8  saturating count of HUNT timeouts and losses of sync.

## Operation
- States: IDLE, INIT, HUNT, VERIFY, LOCKED. All state and outputs are registered.
- IDLE: `PHY_INIT`=1. Go to INIT when `LINK_EN`=1.
- INIT: `PHY_INIT`=1 for `INIT_CYC` cycles, then go to HUNT with `PHY_INIT`=0 and the hunt counter cleared.
- HUNT: count `DIPUSH` words.
  - On a valid word with `ALIGNED`=1 and `DIN`==SYNC: word position := 1, good count := 1, go to VERIFY. If `LOCK_CNT`==1, go to LOCKED directly.
  - If the hunt counter reaches `HUNT_TO` first: `RETRY_CNT`++, go to INIT.
- Word position counts valid words modulo `FRAME_LEN`. Position 0 is the expected sync slot.
- VERIFY, on each valid word at position 0:
  - `DIN`==SYNC: good count++. Go to LOCKED when good count reaches `LOCK_CNT`.
  - `DIN`!=SYNC: `RETRY_CNT`++, go to INIT.
- LOCKED, on each valid word at position 0:
  - `DIN`==SYNC: miss count := 0.
  - `DIN`!=SYNC: miss count++. At `UNLOCK_CNT` misses: `LOS` pulse, `RETRY_CNT`++, go to INIT.
  - The word position keeps free-running through misses; the controller never re-hunts while in LOCKED.
- Forwarding: only in LOCKED, only words at positions 1..`FRAME_LEN`-1. `DOUT` := `DIN`, `DOPUSH` := 1. `FRAME_START`=1 on position 1.
- A word at position 0 is never forwarded, even when it is a miss.
- `LINK_EN`=0 in any state: go to IDLE next cycle; `DOPUSH`, `LOCKED`, `LOS` go to 0. `RETRY_CNT` holds its value.
- `ALIGNED` falling in VERIFY or LOCKED: go to INIT next cycle with `RETRY_CNT`++. This takes priority over word checks in the same cycle. `LOS` pulses only if leaving LOCKED.
- `RETRY_CNT` saturates at 255.

## Timing
- Reset (`RSTX`=0 at a clock edge): state IDLE, `PHY_INIT`=1, `DOPUSH`=0, `DOUT`=0, `FRAME_START`=0, `LOCKED`=0, `LOS`=0, `RETRY_CNT`=0. All internal counters are 0.
- Reset asserted mid-frame wins over every other event.
- `PHY_INIT` rises 1 cycle after entering INIT conditions. It stays high exactly `INIT_CYC` cycles measured from the INIT entry edge, and is also high throughout IDLE.
- Payload latency: `DOPUSH`/`DOUT` appear 1 cycle after the `DIPUSH`/`DIN` cycle.
- No backpressure: each valid input gives at most one output. Gaps in `DIPUSH` stall the word counter.
- `LOCKED` rises in the cycle after the `LOCK_CNT`-th sync is accepted. The first payload word forwarded is at position 1 of the next frame.
- `LOS` and the `LOCKED` fall occur in the same cycle.
- Priority within one cycle: reset > `LINK_EN`=0 > `ALIGNED` fall > word check.

## Structure
- Shared package `align_pkg`:
  - `SYNC_WORD` = 32'hF731_8CEF; `word_align` should also take it from here.
  - State encoding localparams `ST_IDLE`, `ST_INIT`, `ST_HUNT`, `ST_VERIFY`, `ST_LOCKED`.
- One natural sub-module, `frame_pos_cnt`: the modulo-`FRAME_LEN` word-position counter with load-to-1 and enable. Everything else (FSM, hunt/good/miss counters, output registers) stays in `align_lock_ctrl`.
- Counter widths use `$clog2` of their parameter.

## Test plan
- Clean lock: `LINK_EN`=1; aligner fed a stream with SYNC every 64 words → `PHY_INIT` high 4 cycles, `LOCKED` high after the 3rd sync, first `DOPUSH` at position 1 with `FRAME_START`=1, SYNC words never forwarded.
- Hunt timeout: no SYNC for 1024 valid words → `RETRY_CNT`=1, `PHY_INIT` high 4 cycles, HUNT restarts; repeat 300 times → `RETRY_CNT`=255, held.
- Verify fail: SYNC at word 0, corrupted at word 64 → return to INIT, `LOCKED` never set, `RETRY_CNT`=1.
- Loss of sync: locked, then 3 corrupted syncs followed by 1 good → stays LOCKED. Then 4 consecutive bad syncs → `LOS` pulse, `LOCKED`=0, `PHY_INIT`=1.
- Disruption: locked, `ALIGNED` drops mid-frame → INIT next cycle with `LOS`. `LINK_EN`=0 mid-frame → IDLE, `DOPUSH`=0 immediately.
- Reset: `RSTX`=0 mid-payload → all outputs at reset values at the next edge, `PHY_INIT`=1. Also check that gaps in `DIPUSH` do not shift the frame position.
